// File: rtl/fpu_pkg.sv
// Shared FPU definitions: float field widths, exponent bias, status encoding and
// the integer-to-float conversion state set.
package fpu_pkg;

    localparam int EXP_W   = 7;
    localparam int FRAC_W  = 24;
    localparam int FP_BIAS = 63;

    typedef enum logic [3:0] {
        ST_EXACT     = 4'b0001,
        ST_INEXACT   = 4'b0010,
        ST_OVERFLOW  = 4'b0100,
        ST_UNDERFLOW = 4'b1000
    } status_t;

    typedef enum logic [2:0] {
        CV_IDLE,
        CV_ABS,
        CV_NORMALIZE,
        CV_ROUND,
        CV_PACK
    } cvt_state_t;

endpackage

// File: rtl/fpu_int2fp_if.sv
// Request/result bundle between an operand source and the int-to-float converter.
interface fpu_int2fp_if
    import fpu_pkg::*;
;
    logic                      start;
    logic [31:0]               int_in;
    logic                      is_signed;
    logic                      busy;
    logic                      done;
    logic [EXP_W+FRAC_W:0]     data_out;
    logic [3:0]                status_out;

    modport master (
        output start, int_in, is_signed,
        input  busy, done, data_out, status_out
    );

    modport slave (
        input  start, int_in, is_signed,
        output busy, done, data_out, status_out
    );
endinterface

// File: rtl/fpu_int2fp.sv
// Integer to 32-bit float {sign, exp[6:0] bias 63, frac[23:0]} converter with
// serial one-bit-per-cycle normalisation and round-to-nearest-even.
//
// state        | meaning
// CV_IDLE      | waiting for start; operand captured on accept
// CV_ABS       | take sign and magnitude, preset exponent; zero goes straight to pack
// CV_NORMALIZE | shift magnitude left until bit 31 is set, one bit per cycle
// CV_ROUND     | round-to-nearest-even on the top 25 bits, renormalise on carry
// CV_PACK      | register result word and status, pulse done
module fpu_int2fp
    import fpu_pkg::*;
#(
    parameter int INT_W = 32,
    parameter int BIAS  = FP_BIAS
) (
    input  logic          clock,
    input  logic          reset,
    fpu_int2fp_if.slave   bus
);

    cvt_state_t         state_q, state_d;
    logic [INT_W-1:0]   int_q, int_d;
    logic               signed_q, signed_d;
    logic               sign_q, sign_d;
    logic [INT_W-1:0]   mag_q, mag_d;
    logic [7:0]         exp_q, exp_d;
    logic [FRAC_W-1:0]  frac_q, frac_d;
    logic               inexact_q, inexact_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         status_q, status_d;
    logic               done_q, done_d;

    logic               guard, sticky, round_up, carry;
    logic [FRAC_W-1:0]  frac_rnd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= CV_IDLE;
            int_q     <= '0;
            signed_q  <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            exp_q     <= '0;
            frac_q    <= '0;
            inexact_q <= 1'b0;
            data_q    <= '0;
            status_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            signed_q  <= signed_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            frac_q    <= frac_d;
            inexact_q <= inexact_d;
            data_q    <= data_d;
            status_q  <= status_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        signed_d  = signed_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        frac_d    = frac_q;
        inexact_d = inexact_q;
        data_d    = data_q;
        status_d  = status_q;
        done_d    = 1'b0;

        // Bit 31 is the implicit one, so only the 24 fraction bits take the increment;
        // a carry out of them means the significand rolled over to 2.0.
        guard             = mag_q[6];
        sticky            = |mag_q[5:0];
        round_up          = guard & (sticky | mag_q[7]);
        {carry, frac_rnd} = {1'b0, mag_q[30:7]} + {{FRAC_W{1'b0}}, round_up};

        case (state_q)
            CV_IDLE: begin
                if (bus.start) begin
                    int_d    = bus.int_in;
                    signed_d = bus.is_signed;
                    state_d  = CV_ABS;
                end
            end
            CV_ABS: begin
                sign_d = signed_q & int_q[INT_W-1];
                mag_d  = sign_d ? -int_q : int_q;
                exp_d  = 8'(BIAS + INT_W - 1);
                if (int_q == '0) begin
                    sign_d    = 1'b0;
                    exp_d     = '0;
                    frac_d    = '0;
                    inexact_d = 1'b0;
                    state_d   = CV_PACK;
                end else begin
                    state_d = CV_NORMALIZE;
                end
            end
            CV_NORMALIZE: begin
                if (!mag_q[INT_W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end else begin
                    state_d = CV_ROUND;
                end
            end
            CV_ROUND: begin
                frac_d    = frac_rnd;
                exp_d     = exp_q + 8'(carry);
                inexact_d = guard | sticky;
                state_d   = CV_PACK;
            end
            CV_PACK: begin
                data_d = {sign_q, exp_q[EXP_W-1:0], frac_q};
                // The exponent cannot reach 128 for a 32-bit source; the check only
                // matters if the block is ever widened.
                if (exp_q[7])
                    status_d = ST_OVERFLOW;
                else if (inexact_q)
                    status_d = ST_INEXACT;
                else
                    status_d = ST_EXACT;
                done_d  = 1'b1;
                state_d = CV_IDLE;
            end
            default: state_d = CV_IDLE;
        endcase
    end

    assign bus.busy       = (state_q != CV_IDLE);
    assign bus.done       = done_q;
    assign bus.data_out   = data_q;
    assign bus.status_out = status_q;

endmodule
